// File: rtl/mem_bus_arbiter.sv
// Shares one 32-bit memory bus between the CPU fetch and data ports.
// Data takes priority; a stall is held until every access for the current step completes.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    input  logic [3:0]  mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_DACC, S_IACC, S_DRAIN} state_t;

    state_t      r_state;
    logic        r_d_done;
    logic        r_i_done;
    logic [31:0] r_wait;
    logic        w_mem_req;
    logic        w_timeout;
    logic        w_done;

    assign w_mem_req  = |mem_ce_i;
    assign w_timeout  = (TIMEOUT_CYC != 0) && bus_req_o && !bus_ack_i
                        && (r_wait == TIMEOUT_CYC - 1);
    assign w_done     = (bus_req_o && bus_ack_i) || w_timeout;
    assign stallreq_o = !rst && ((w_mem_req && !r_d_done) || (if_ce_i && !r_i_done)
                                 || (r_state == S_DRAIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_d_done    <= 1'b0;
            r_i_done    <= 1'b0;
            r_wait      <= '0;
            if_data_o   <= '0;
            mem_data_o  <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            timeout_o <= w_timeout;
            r_wait    <= (bus_req_o && !bus_ack_i) ? r_wait + 32'd1 : '0;
            if (flush || !stallreq_o) begin
                r_d_done <= 1'b0;
                r_i_done <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!flush) begin
                        if (w_mem_req && !r_d_done) begin
                            r_state     <= S_DACC;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_we_i;
                            bus_sel_o   <= mem_sel_i;
                            bus_addr_o  <= mem_addr_i;
                            bus_wdata_o <= mem_data_i;
                        end else if (if_ce_i && !r_i_done) begin
                            r_state     <= S_IACC;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= 1'b0;
                            bus_sel_o   <= 4'b1111;
                            bus_addr_o  <= if_addr_i;
                            bus_wdata_o <= '0;
                        end
                    end
                end
                S_DACC, S_IACC: begin
                    // A flush coinciding with completion discards the data and skips DRAIN.
                    if (w_done) begin
                        r_state   <= S_IDLE;
                        bus_req_o <= 1'b0;
                        r_wait    <= '0;
                        if (!flush) begin
                            if (r_state == S_DACC) begin
                                mem_data_o <= (w_timeout || bus_we_o) ? '0 : bus_rdata_i;
                                r_d_done   <= 1'b1;
                            end else begin
                                if_data_o <= w_timeout ? '0 : bus_rdata_i;
                                r_i_done  <= 1'b1;
                            end
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                        r_wait  <= '0;
                    end
                end
                S_DRAIN: begin
                    if (w_done) begin
                        r_state   <= S_IDLE;
                        bus_req_o <= 1'b0;
                        r_wait    <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected bus transactions,
// stall releases and timeouts; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush, if_ce_i, mem_we_i, bus_ack_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_data_i, bus_rdata_i;
    logic [3:0]  mem_ce_i, mem_sel_i;
    logic [31:0] if_data_o, mem_data_o, bus_addr_o, bus_wdata_o;
    logic        stallreq_o, bus_req_o, bus_we_o, timeout_o;
    logic [3:0]  bus_sel_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .stallreq_o(stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .timeout_o(timeout_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {logic [31:0] addr; logic we; logic [3:0] sel; logic [31:0] wdata; int len;} bus_t;
    typedef struct {int stall; bit ci; logic [31:0] idata; bit cm; logic [31:0] mdata;} rel_t;
    typedef struct {int wait_n; logic [31:0] rdata;} rsp_t;

    bus_t        bus_q[$];
    rel_t        rel_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] to_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Memory responder: each bus transaction acks after wait_n wait cycles.
    initial begin
        rsp_t cur;
        int   rcnt;
        logic r_prev;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '1;
        r_prev      = 1'b0;
        cur         = '{1000, 32'h0};
        rcnt        = 0;
        forever begin
            @(negedge clk);
            if (bus_req_o) begin
                if (!r_prev) begin
                    cur  = (rsp_q.size() > 0) ? rsp_q.pop_front() : '{1000, 32'h0};
                    rcnt = 0;
                end
                if (rcnt == cur.wait_n) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = cur.rdata;
                end else begin
                    bus_ack_i   = 1'b0;
                    bus_rdata_i = '1;
                end
                rcnt++;
            end else begin
                bus_ack_i   = 1'b0;
                bus_rdata_i = '1;
            end
            r_prev = bus_req_o;
        end
    end

    // Monitor: bus transactions, stall releases and timeout pulses.
    initial begin
        bus_t cur_b;
        rel_t cur_r;
        bit   have_b;
        logic m_prev, s_prev;
        int   blen, slen;
        have_b = 0;
        m_prev = 1'b0;
        s_prev = 1'b0;
        blen   = 0;
        slen   = 0;
        forever begin
            @(negedge clk);
            if (bus_req_o && !m_prev) begin
                blen = 0;
                if (bus_q.size() == 0) begin
                    fail_now("unexpected_bus_txn");
                end else begin
                    cur_b  = bus_q.pop_front();
                    have_b = 1;
                    chk("bus_addr", bus_addr_o, cur_b.addr);
                    chk("bus_we", 32'(bus_we_o), 32'(cur_b.we));
                    chk("bus_sel", 32'(bus_sel_o), 32'(cur_b.sel));
                    chk("bus_wdata", bus_wdata_o, cur_b.wdata);
                end
            end
            if (bus_req_o) blen++;
            if (!bus_req_o && m_prev && have_b) begin
                chk("bus_req_len", 32'(blen), 32'(cur_b.len));
                have_b = 0;
            end
            m_prev = bus_req_o;

            if (stallreq_o) slen++;
            if (!stallreq_o && s_prev) begin
                if (rel_q.size() == 0) begin
                    fail_now("unexpected_release");
                end else begin
                    cur_r = rel_q.pop_front();
                    chk("stall_len", 32'(slen), 32'(cur_r.stall));
                    if (cur_r.ci) chk("if_data", if_data_o, cur_r.idata);
                    if (cur_r.cm) chk("mem_data", mem_data_o, cur_r.mdata);
                end
                slen = 0;
            end
            s_prev = stallreq_o;

            if (timeout_o) begin
                if (to_q.size() == 0) fail_now("unexpected_timeout");
                else chk("timeout_addr", bus_addr_o, to_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_release(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (stallreq_o && n < 40);
        if (stallreq_o) fail_now({name, "_stall_timeout"});
    endtask

    task automatic clear_reqs();
        if_ce_i    = 1'b0;
        mem_ce_i   = '0;
        mem_we_i   = 1'b0;
        mem_sel_i  = '0;
        mem_data_i = '0;
        step();
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stallreq_o), 32'h0);
        chk({tag, "_req"}, 32'(bus_req_o), 32'h0);
        chk({tag, "_we"}, 32'(bus_we_o), 32'h0);
        chk({tag, "_sel"}, 32'(bus_sel_o), 32'h0);
        chk({tag, "_addr"}, bus_addr_o, 32'h0);
        chk({tag, "_wdata"}, bus_wdata_o, 32'h0);
        chk({tag, "_if_data"}, if_data_o, 32'h0);
        chk({tag, "_mem_data"}, mem_data_o, 32'h0);
        chk({tag, "_timeout"}, 32'(timeout_o), 32'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        if_ce_i = 1'b0; if_addr_i = '0;
        mem_ce_i = '0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0;
        repeat (3) step();
        if_ce_i = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");
        step();
        if_ce_i = 1'b0;
        rst     = 1'b0;
        step();
        step();

        // Single zero-wait fetch
        rsp_q.push_back('{0, 32'h2401_0005});
        bus_q.push_back('{32'h100, 1'b0, 4'hF, 32'h0, 1});
        rel_q.push_back('{2, 1, 32'h2401_0005, 0, 32'h0});
        if_ce_i = 1'b1; if_addr_i = 32'h100;
        wait_release("fetch");
        clear_reqs();

        // Load with 3 wait states
        rsp_q.push_back('{3, 32'hDEAD_BEEF});
        bus_q.push_back('{32'h200, 1'b0, 4'hF, 32'h1111_2222, 4});
        rel_q.push_back('{5, 1, 32'h2401_0005, 1, 32'hDEAD_BEEF});
        mem_ce_i = 4'hF; mem_sel_i = 4'hF; mem_addr_i = 32'h200; mem_data_i = 32'h1111_2222;
        wait_release("wait_load");
        clear_reqs();

        // Store and fetch together: store first, writes leave a zero result
        rsp_q.push_back('{0, 32'h5555_5555});
        rsp_q.push_back('{0, 32'h8C02_0000});
        bus_q.push_back('{32'h80, 1'b1, 4'b0011, 32'hABCD, 1});
        bus_q.push_back('{32'h104, 1'b0, 4'hF, 32'h0, 1});
        rel_q.push_back('{4, 1, 32'h8C02_0000, 1, 32'h0});
        mem_ce_i = 4'b0011; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h80; mem_data_i = 32'hABCD;
        if_ce_i = 1'b1; if_addr_i = 32'h104;
        wait_release("collision");
        clear_reqs();

        // Load with one wait state
        rsp_q.push_back('{1, 32'h0BAD_F00D});
        bus_q.push_back('{32'h204, 1'b0, 4'hF, 32'h0, 2});
        rel_q.push_back('{3, 0, 32'h0, 1, 32'h0BAD_F00D});
        mem_ce_i = 4'b1000; mem_sel_i = 4'hF; mem_addr_i = 32'h204;
        wait_release("load1");
        clear_reqs();

        // Non-responding device: forced completion after 4 wait cycles
        rsp_q.push_back('{1000, 32'h0});
        bus_q.push_back('{32'h600, 1'b0, 4'b0100, 32'h0, 4});
        rel_q.push_back('{5, 0, 32'h0, 1, 32'h0});
        to_q.push_back(32'h600);
        mem_ce_i = 4'b0100; mem_sel_i = 4'b0100; mem_addr_i = 32'h600;
        wait_release("timeout");
        clear_reqs();

        // Flush on the 2nd wait cycle of a fetch: drain, then refetch new_pc
        rsp_q.push_back('{4, 32'hBAD0_BAD0});
        rsp_q.push_back('{0, 32'h2402_0007});
        bus_q.push_back('{32'h300, 1'b0, 4'hF, 32'h0, 5});
        bus_q.push_back('{32'h400, 1'b0, 4'hF, 32'h0, 1});
        rel_q.push_back('{8, 1, 32'h2402_0007, 0, 32'h0});
        if_ce_i = 1'b1; if_addr_i = 32'h300;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; if_addr_i = 32'h400;
        wait_release("flush_drain");
        clear_reqs();

        // Flush coinciding with ack: no drain, immediate refetch
        rsp_q.push_back('{1, 32'hBAD1_BAD1});
        rsp_q.push_back('{0, 32'h2403_0009});
        bus_q.push_back('{32'h500, 1'b0, 4'hF, 32'h0, 2});
        bus_q.push_back('{32'h504, 1'b0, 4'hF, 32'h0, 1});
        rel_q.push_back('{5, 1, 32'h2403_0009, 0, 32'h0});
        if_ce_i = 1'b1; if_addr_i = 32'h500;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; if_addr_i = 32'h504;
        wait_release("flush_ack");
        clear_reqs();

        // Reset during a data access
        rsp_q.push_back('{1000, 32'h0});
        bus_q.push_back('{32'h700, 1'b1, 4'hF, 32'h77, 2});
        rel_q.push_back('{2, 1, 32'h2403_0009, 1, 32'h0});
        mem_ce_i = 4'hF; mem_we_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h700; mem_data_i = 32'h77;
        step();
        step();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst_mid");
        step();
        rst = 1'b0;
        clear_reqs();
        repeat (3) step();

        chk("bus_q_left", 32'(bus_q.size()), 32'h0);
        chk("rel_q_left", 32'(rel_q.size()), 32'h0);
        chk("to_q_left", 32'(to_q.size()), 32'h0);
        chk("rsp_q_left", 32'(rsp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
